sram_data_slave: RTL

Single-port SRAM-like responder that serves the data-side request stream issued by the memory stage (req/wr/size/addr/wdata) from an on-chip word array. It completes each transfer with an addr_ok/data_ok handshake after a programmable latency. It sits on the CPU's data SRAM-like port, in simulation benches and in the minimal SoC, standing in for the cache/AXI bridge. One transfer is outstanding at a time, and responses are returned in order.

---
 rtl/cpu_defs.sv | 15 +
 rtl/sram_be_gen.sv | 30 +++
 rtl/sram_data_slave.sv | 96 +++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU-side definitions: SRAM-like transfer size codes and the data
// slave FSM state type.
package cpu_defs;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } sram_slv_state_t;

endpackage

// File: rtl/sram_be_gen.sv
// Byte-enable decode from SRAM-like transfer size and byte offset.
// Size 2 carries the SWL/SWR partial-word lane patterns as well as full words.
module sram_be_gen
  import cpu_defs::*;
(
  input  logic [1:0] i_size,
  input  logic [1:0] i_off,
  output logic [3:0] o_be
);

  always_comb begin
    o_be = 4'b0000;
    case (i_size)
      SZ_BYTE: o_be = 4'b0001 << i_off;
      SZ_HALF: begin
        if (!i_off[0]) o_be = i_off[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        case (i_off)
          2'd0:    o_be = 4'b1111;
          2'd1:    o_be = 4'b1110;
          2'd2:    o_be = 4'b0111;
          default: o_be = 4'b0000;
        endcase
      end
      default: o_be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/sram_data_slave.sv
// SRAM-like data-port responder backed by an on-chip word array; one transfer
// outstanding, completed with data_ok exactly LATENCY cycles after acceptance.
module sram_data_slave
  import cpu_defs::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int unsigned Depth   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  sram_slv_state_t r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [Depth];
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [3:0]            w_be;
  logic                  w_accept;

  assign w_idx        = data_addr[ADDR_WIDTH+1:2];
  // Handshake depends on state only, so data_req never reaches addr_ok.
  assign data_addr_ok = (r_state != S_WAIT);
  assign data_data_ok = (r_state == S_RESP);
  assign data_rdata   = r_rdata;
  assign w_accept     = data_req & data_addr_ok;

  sram_be_gen u_be_gen (
    .i_size (data_size),
    .i_off  (data_addr[1:0]),
    .o_be   (w_be)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CntInit;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'd0;
    end else if (w_accept && !data_wr) begin
      r_rdata <= r_mem[w_idx];
    end
  end

  // Array is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_accept && data_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= data_wdata[8*i +: 8];
      end
    end
  end

endmodule
